// File: rtl/alu_pkg.sv
// Shared constants for the wishbone ALU: register/op addresses, flag bit
// positions and the multiplier FSM states.
package alu_pkg;

  localparam logic [7:0] ADDR_A     = 8'h00;
  localparam logic [7:0] ADDR_B     = 8'h01;
  localparam logic [7:0] ADDR_FLAGS = 8'h02;
  localparam logic [7:0] ADDR_HI    = 8'h03;

  localparam logic [7:0] OP_ADD = 8'h80;
  localparam logic [7:0] OP_ADC = 8'h81;
  localparam logic [7:0] OP_SUB = 8'h82;
  localparam logic [7:0] OP_SBC = 8'h83;
  localparam logic [7:0] OP_AND = 8'h84;
  localparam logic [7:0] OP_OR  = 8'h85;
  localparam logic [7:0] OP_XOR = 8'h86;
  localparam logic [7:0] OP_ASL = 8'h87;
  localparam logic [7:0] OP_LSR = 8'h88;
  localparam logic [7:0] OP_MUL = 8'h89;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// after i_start. o_prod is the accumulator value that the current step produces.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_busy    = (r_cnt != '0);
  // Final step is in flight: o_prod now holds the complete product.
  assign o_done    = (r_cnt == CNT_W'(1));
  assign o_prod    = w_acc_nxt;

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (o_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_wb_pipe.sv
// Pipelined wishbone ALU slave: A/B/FLAGS/HI registers, single-cycle ops
// computed on read with 6502-style flags, and a stalling iterative multiply.
module alu_wb_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [WIDTH-1:0]  i_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic [WIDTH-1:0]  o_wb_data
);

  localparam int MSB = WIDTH - 1;

  state_e              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_a, r_b, r_hi, r_data;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_ack;

  logic                w_accept, w_mul_start, w_mul_busy, w_mul_done, w_mul_fin;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_bop, w_res, w_rd_data;
  logic                w_cin, w_ovf, w_is_op, w_is_sub, w_use_c;
  logic [WIDTH:0]      w_sum;
  logic [FLAG_W-1:0]   w_flags_nxt;

  assign o_wb_stall = (r_state == ST_BUSY);
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_data;
  assign w_accept   = i_wb_stb && !o_wb_stall;
  assign w_mul_fin  = (r_state == ST_BUSY) && w_mul_done;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (i_clk),
    .reset   (reset),
    .i_start (w_mul_start),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge i_clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !i_wb_we && (i_wb_addr == ADDR_W'(OP_MUL))) begin
          w_mul_start = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_mul_done || !w_mul_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Adder shared by ADD/ADC/SUB/SBC: subtraction is A + ~B + carry-in.
  assign w_is_sub = (i_wb_addr == ADDR_W'(OP_SUB)) || (i_wb_addr == ADDR_W'(OP_SBC));
  assign w_use_c  = (i_wb_addr == ADDR_W'(OP_ADC)) || (i_wb_addr == ADDR_W'(OP_SBC));
  assign w_bop    = w_is_sub ? ~r_b : r_b;
  assign w_cin    = w_use_c ? r_flags[FLAG_C] : w_is_sub;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf    = (r_a[MSB] == w_bop[MSB]) && (w_sum[MSB] != r_a[MSB]);

  always_comb begin
    w_rd_data   = '0;
    w_res       = '0;
    w_is_op     = 1'b0;
    w_flags_nxt = r_flags;
    case (i_wb_addr)
      ADDR_W'(ADDR_A):     w_rd_data = r_a;
      ADDR_W'(ADDR_B):     w_rd_data = r_b;
      ADDR_W'(ADDR_FLAGS): w_rd_data = WIDTH'(r_flags);
      ADDR_W'(ADDR_HI):    w_rd_data = r_hi;
      ADDR_W'(OP_ADD), ADDR_W'(OP_ADC), ADDR_W'(OP_SUB), ADDR_W'(OP_SBC): begin
        w_is_op             = 1'b1;
        w_res               = w_sum[WIDTH-1:0];
        w_flags_nxt[FLAG_C] = w_sum[WIDTH];
        w_flags_nxt[FLAG_V] = w_ovf;
      end
      ADDR_W'(OP_AND): begin w_is_op = 1'b1; w_res = r_a & r_b; end
      ADDR_W'(OP_OR):  begin w_is_op = 1'b1; w_res = r_a | r_b; end
      ADDR_W'(OP_XOR): begin w_is_op = 1'b1; w_res = r_a ^ r_b; end
      ADDR_W'(OP_ASL): begin
        w_is_op             = 1'b1;
        w_res               = {r_a[MSB-1:0], 1'b0};
        w_flags_nxt[FLAG_C] = r_a[MSB];
      end
      ADDR_W'(OP_LSR): begin
        w_is_op             = 1'b1;
        w_res               = {1'b0, r_a[MSB:1]};
        w_flags_nxt[FLAG_C] = r_a[0];
      end
      default: ;
    endcase
    if (w_is_op) begin
      w_rd_data           = w_res;
      w_flags_nxt[FLAG_Z] = (w_res == '0);
      w_flags_nxt[FLAG_N] = w_res[MSB];
    end
  end

  // A multiply read is acked only when the product lands, not on acceptance.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_mul_fin) begin
        r_ack           <= 1'b1;
        r_data          <= w_prod[WIDTH-1:0];
        r_hi            <= w_prod[2*WIDTH-1:WIDTH];
        r_flags[FLAG_Z] <= (w_prod == '0);
        r_flags[FLAG_N] <= w_prod[2*WIDTH-1];
        r_flags[FLAG_C] <= |w_prod[2*WIDTH-1:WIDTH];
      end else if (w_accept && !w_mul_start) begin
        r_ack <= 1'b1;
        if (i_wb_we) begin
          if (i_wb_addr == ADDR_W'(ADDR_A))     r_a     <= i_wb_data;
          if (i_wb_addr == ADDR_W'(ADDR_B))     r_b     <= i_wb_data;
          if (i_wb_addr == ADDR_W'(ADDR_FLAGS)) r_flags <= i_wb_data[FLAG_W-1:0];
        end else begin
          r_data <= w_rd_data;
          if (w_is_op) r_flags <= w_flags_nxt;
        end
      end
    end
  end

endmodule
